// File: rtl/mem_read_initiator.sv
// -----------------------------------------------------------------------------
// mem_read_initiator
// Requester side of the 16-bit addr/data read port of the memory hierarchy.
// Given a base address and a word count it issues one read at a time on
// mem_addr, samples mem_data a fixed RD_LATENCY cycles after the issue cycle,
// and presents each word on a valid/ready stream. A one-cycle done pulse marks
// the end of the burst.
//
// Build option:
//   MEM_RD_CHECKSUM_EN  defined   -> running 16-bit checksum of accepted words
//                       undefined -> no accumulator, checksum tied to zero
//
// Parameters:
//   RD_LATENCY  cycles from issue to the sampling edge (0 = combinational
//               responder, sampled at the end of the issue cycle)
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   request a burst (honoured only while idle)
//   base_addr  in   first address of the burst, captured on start
//   count      in   number of words, captured on start
//   mem_addr   out  address to the responder (holds last issued while idle)
//   mem_rd     out  one-cycle read strobe in the issue cycle
//   mem_data   in   responder data
//   out_data   out  captured word
//   out_valid  out  out_data is valid
//   out_ready  in   downstream accepts when high with out_valid
//   busy       out  high in every state except idle
//   done       out  one-cycle pulse at burst end
//   checksum   out  running sum of the burst's accepted words
// -----------------------------------------------------------------------------
module mem_read_initiator #(
   parameter int RD_LATENCY = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] base_addr,
   input  logic [15:0] count,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_data,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] checksum
);

   localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD =
      (RD_LATENCY > 0) ? LAT_W'(RD_LATENCY - 1) : {LAT_W{1'b0}};
   localparam logic COMB_RESP = (RD_LATENCY == 32'sd0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t            state_r, state_next_s;
   logic [15:0]       cur_addr_r, cur_addr_next_s;
   logic [15:0]       remaining_r, remaining_next_s;
   logic [LAT_W-1:0]  lat_cnt_r, lat_cnt_next_s;
   logic              start_take_s;
   logic              accept_s;
   logic              capture_s;

   // Next-state, burst bookkeeping and sampling decisions.
   always_comb begin
      state_next_s     = state_r;
      cur_addr_next_s  = cur_addr_r;
      remaining_next_s = remaining_r;
      lat_cnt_next_s   = lat_cnt_r;
      capture_s        = 1'b0;
      accept_s         = 1'b0;
      start_take_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               start_take_s     = 1'b1;
               cur_addr_next_s  = base_addr;
               remaining_next_s = count;
               // An empty burst goes straight to the done pulse, no read.
               if (count != 16'd0) begin
                  state_next_s = ST_ISSUE;
               end else begin
                  state_next_s = ST_DONE;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (COMB_RESP) begin
               capture_s    = 1'b1;
               state_next_s = ST_HOLD;
            end else begin
               // Counter counts down to zero; the sample happens in the last WAIT.
               lat_cnt_next_s = LAT_LOAD;
               state_next_s   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_r == {LAT_W{1'b0}}) begin
               capture_s    = 1'b1;
               state_next_s = ST_HOLD;
            end else begin
               lat_cnt_next_s = lat_cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               accept_s = 1'b1;
               if (remaining_r == 16'd1) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_ISSUE;
               end
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      if (accept_s) begin
         cur_addr_next_s  = cur_addr_r + 16'd1;
         remaining_next_s = remaining_r - 16'd1;
      end else begin
         cur_addr_next_s  = cur_addr_next_s;
      end
   end

   // State register, burst registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cur_addr_r  <= 16'd0;
         remaining_r <= 16'd0;
         lat_cnt_r   <= {LAT_W{1'b0}};
         mem_addr    <= 16'd0;
         mem_rd      <= 1'b0;
         out_data    <= 16'd0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         cur_addr_r  <= cur_addr_next_s;
         remaining_r <= remaining_next_s;
         lat_cnt_r   <= lat_cnt_next_s;
         // mem_addr only moves on entering ISSUE, so it holds through WAIT/HOLD
         // and keeps the last issued address while idle.
         if (state_next_s == ST_ISSUE) begin
            mem_addr <= cur_addr_next_s;
         end
         if (capture_s) begin
            out_data <= mem_data;
         end
         mem_rd    <= (state_next_s == ST_ISSUE);
         out_valid <= (state_next_s == ST_HOLD);
         busy      <= (state_next_s != ST_IDLE);
         done      <= (state_next_s == ST_DONE);
      end
   end

`ifdef MEM_RD_CHECKSUM_EN
   logic [15:0] checksum_r;

   // Running checksum: cleared on an accepted start, summed on each handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         checksum_r <= 16'd0;
      end else if (start_take_s) begin
         checksum_r <= 16'd0;
      end else if (accept_s) begin
         checksum_r <= checksum_r + out_data;
      end
   end

   assign checksum = checksum_r;
`else
   assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_mem_read_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_read_initiator
// Scoreboard bench: stimulus pushes expected words (value + acceptance cycle)
// and expected done pulses (checksum + cycle) into queues; per-DUT monitors pop
// and compare on each handshake / done pulse. Two instances: RD_LATENCY = 0
// with an identity responder, RD_LATENCY = 3 with a 3-cycle delayed one.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mem_read_initiator;

   typedef struct {
      logic [15:0] v;
      int          c;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic reset;

   logic        start0, mem_rd0, out_valid0, out_ready0, busy0, done0;
   logic [15:0] base0, count0, mem_addr0, mem_data0, out_data0, checksum0;
   logic        start3, mem_rd3, out_valid3, out_ready3, busy3, done3;
   logic [15:0] base3, count3, mem_addr3, mem_data3, out_data3, checksum3;
   logic [15:0] d1, d2, d3;

   exp_t wq0[$], dq0[$], wq3[$], dq3[$];
   int n_checks = 0;
   int n_pass   = 0;

   mem_read_initiator #(.RD_LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .base_addr(base0),
      .count(count0), .mem_addr(mem_addr0), .mem_rd(mem_rd0),
      .mem_data(mem_data0), .out_data(out_data0), .out_valid(out_valid0),
      .out_ready(out_ready0), .busy(busy0), .done(done0),
      .checksum(checksum0));

   mem_read_initiator #(.RD_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .base_addr(base3),
      .count(count3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
      .mem_data(mem_data3), .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .busy(busy3), .done(done3),
      .checksum(checksum3));

   // Identity responders: combinational for dut0, 3-cycle pipeline for dut3.
   assign mem_data0 = mem_addr0;
   always @(posedge clk) begin
      d1 <= mem_addr3;
      d2 <= d1;
      d3 <= d2;
   end
   assign mem_data3 = d3;

   function automatic logic [15:0] xs(input logic [15:0] s);
`ifdef MEM_RD_CHECKSUM_EN
      return s;
`else
      return 16'd0;
`endif
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Monitor for dut0.
   always @(negedge clk) begin : mon0
      exp_t e;
      if (out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
         if (wq0.size() == 0) begin
            n_checks++;
            $display("FAIL dut0_word: got %h expected none (cycle %0d)", out_data0, cyc);
         end else begin
            e = wq0.pop_front();
            check("dut0_word", {16'd0, out_data0}, {16'd0, e.v});
            check("dut0_word_cyc", cyc, e.c);
         end
      end
      if (done0 === 1'b1) begin
         if (dq0.size() == 0) begin
            n_checks++;
            $display("FAIL dut0_done: got pulse expected none (cycle %0d)", cyc);
         end else begin
            e = dq0.pop_front();
            check("dut0_checksum", {16'd0, checksum0}, {16'd0, e.v});
            check("dut0_done_cyc", cyc, e.c);
         end
      end
   end

   // Monitor for dut3.
   always @(negedge clk) begin : mon3
      exp_t e;
      if (out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
         if (wq3.size() == 0) begin
            n_checks++;
            $display("FAIL dut3_word: got %h expected none (cycle %0d)", out_data3, cyc);
         end else begin
            e = wq3.pop_front();
            check("dut3_word", {16'd0, out_data3}, {16'd0, e.v});
            check("dut3_word_cyc", cyc, e.c);
         end
      end
      if (done3 === 1'b1) begin
         if (dq3.size() == 0) begin
            n_checks++;
            $display("FAIL dut3_done: got pulse expected none (cycle %0d)", cyc);
         end else begin
            e = dq3.pop_front();
            check("dut3_checksum", {16'd0, checksum3}, {16'd0, e.v});
            check("dut3_done_cyc", cyc, e.c);
         end
      end
   end

   // Move to cycle k, 1 ns after its starting edge.
   task automatic to_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Move to the sampling point (falling edge) of cycle k.
   task automatic to_neg(input int k);
      to_cyc(k);
      @(negedge clk);
   endtask

   task automatic push(input int which, input logic [15:0] v, input int c);
      exp_t e;
      e.v = v;
      e.c = c;
      case (which)
         0: wq0.push_back(e);
         1: dq0.push_back(e);
         2: wq3.push_back(e);
         default: dq3.push_back(e);
      endcase
   endtask

   task automatic kick0(input logic [15:0] b, input logic [15:0] n, output int c0);
      @(posedge clk);
      #1;
      c0 = cyc;
      start0 = 1'b1;
      base0  = b;
      count0 = n;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((wq0.size() + dq0.size() + wq3.size() + dq3.size()) != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", wq0.size() + dq0.size() + wq3.size() + dq3.size(), 0);
      wq0.delete(); dq0.delete(); wq3.delete(); dq3.delete();
   endtask

   task automatic chk_reset0(input string tag);
      check({tag, "_mem_addr"},  {16'd0, mem_addr0}, 32'd0);
      check({tag, "_mem_rd"},    {31'd0, mem_rd0},    32'd0);
      check({tag, "_out_data"},  {16'd0, out_data0},  32'd0);
      check({tag, "_out_valid"}, {31'd0, out_valid0}, 32'd0);
      check({tag, "_busy"},      {31'd0, busy0},      32'd0);
      check({tag, "_done"},      {31'd0, done0},      32'd0);
      check({tag, "_checksum"},  {16'd0, checksum0},  32'd0);
   endtask

   initial begin
      int c0;
      reset = 1'b1;
      start0 = 1'b0; base0 = 16'd0; count0 = 16'd0; out_ready0 = 1'b1;
      start3 = 1'b0; base3 = 16'd0; count3 = 16'd0; out_ready3 = 1'b1;
      to_neg(3);
      chk_reset0("rst0");
      check("rst3_mem_addr", {16'd0, mem_addr3}, 32'd0);
      check("rst3_busy", {31'd0, busy3}, 32'd0);
      to_cyc(4);
      reset = 1'b0;

      // Basic burst: 0x0010 x3, words in cycles 2/4/6, done in 7.
      kick0(16'h0010, 16'd3, c0);
      push(0, 16'h0010, c0 + 2); push(0, 16'h0011, c0 + 4); push(0, 16'h0012, c0 + 6);
      push(1, xs(16'h0033), c0 + 7);
      to_cyc(c0 + 1);
      start0 = 1'b0;
      to_neg(c0 + 1);
      check("t1_mem_rd", {31'd0, mem_rd0}, 32'd1);
      check("t1_mem_addr", {16'd0, mem_addr0}, 32'h0010);
      check("t1_busy", {31'd0, busy0}, 32'd1);
      drain(30);
      to_neg(cyc + 1);
      check("t1_idle_addr", {16'd0, mem_addr0}, 32'h0012);
      check("t1_idle_busy", {31'd0, busy0}, 32'd0);
      check("t1_sum_hold", {16'd0, checksum0}, {16'd0, xs(16'h0033)});

      // Address wrap: 0xFFFE, 0xFFFF, 0x0000.
      kick0(16'hFFFE, 16'd3, c0);
      push(0, 16'hFFFE, c0 + 2); push(0, 16'hFFFF, c0 + 4); push(0, 16'h0000, c0 + 6);
      push(1, xs(16'hFFFD), c0 + 7);
      to_cyc(c0 + 1);
      start0 = 1'b0;
      drain(30);

      // Backpressure: ready low for 5 cycles on the first word.
      kick0(16'h0100, 16'd2, c0);
      out_ready0 = 1'b0;
      push(0, 16'h0100, c0 + 7); push(0, 16'h0101, c0 + 9);
      push(1, xs(16'h0201), c0 + 10);
      to_cyc(c0 + 1);
      start0 = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         to_neg(c0 + i);
         check("bp_valid", {31'd0, out_valid0}, 32'd1);
         check("bp_mem_rd", {31'd0, mem_rd0}, 32'd0);
         check("bp_data", {16'd0, out_data0}, 32'h0100);
      end
      to_cyc(c0 + 7);
      out_ready0 = 1'b1;
      to_neg(c0 + 8);
      check("bp_resume_rd", {31'd0, mem_rd0}, 32'd1);
      check("bp_resume_addr", {16'd0, mem_addr0}, 32'h0101);
      drain(30);

      // Empty burst: busy/done for one cycle, no read.
      kick0(16'h0300, 16'd0, c0);
      push(1, 16'h0000, c0 + 1);
      to_cyc(c0 + 1);
      start0 = 1'b0;
      to_neg(c0 + 1);
      check("c0_busy", {31'd0, busy0}, 32'd1);
      check("c0_done", {31'd0, done0}, 32'd1);
      check("c0_mem_rd", {31'd0, mem_rd0}, 32'd0);
      check("c0_addr_hold", {16'd0, mem_addr0}, 32'h0101);
      to_neg(c0 + 2);
      check("c0_busy_end", {31'd0, busy0}, 32'd0);
      check("c0_done_end", {31'd0, done0}, 32'd0);
      check("c0_mem_rd_end", {31'd0, mem_rd0}, 32'd0);
      drain(10);

      // Reset in cycle 3 of a count-4 burst.
      kick0(16'h0200, 16'd4, c0);
      push(0, 16'h0200, c0 + 2);
      to_cyc(c0 + 1);
      start0 = 1'b0;
      to_cyc(c0 + 3);
      reset = 1'b1;
      to_cyc(c0 + 4);
      reset = 1'b0;
      to_neg(c0 + 4);
      chk_reset0("mid_rst");
      to_neg(c0 + 6);
      check("mid_rst_busy", {31'd0, busy0}, 32'd0);
      check("mid_rst_nodone_q", dq0.size(), 0);
      kick0(16'h0005, 16'd1, c0);
      push(0, 16'h0005, c0 + 2);
      push(1, xs(16'h0005), c0 + 3);
      to_cyc(c0 + 1);
      start0 = 1'b0;
      drain(20);

      // RD_LATENCY = 3: valid in cycle 5, start in cycle 3 ignored.
      @(posedge clk);
      #1;
      c0 = cyc;
      start3 = 1'b1; base3 = 16'h1234; count3 = 16'd1;
      push(2, 16'h1234, c0 + 5);
      push(3, xs(16'h1234), c0 + 6);
      to_cyc(c0 + 1);
      start3 = 1'b0;
      to_neg(c0 + 1);
      check("l3_mem_rd", {31'd0, mem_rd3}, 32'd1);
      check("l3_mem_addr", {16'd0, mem_addr3}, 32'h1234);
      to_cyc(c0 + 3);
      start3 = 1'b1; base3 = 16'h5555; count3 = 16'd2;
      to_neg(c0 + 3);
      check("l3_wait_rd", {31'd0, mem_rd3}, 32'd0);
      check("l3_wait_addr", {16'd0, mem_addr3}, 32'h1234);
      to_cyc(c0 + 4);
      start3 = 1'b0;
      to_neg(c0 + 4);
      check("l3_no_valid_yet", {31'd0, out_valid3}, 32'd0);
      drain(20);
      to_neg(c0 + 8);
      check("l3_start_ignored", {31'd0, busy3}, 32'd0);
      check("l3_addr_idle", {16'd0, mem_addr3}, 32'h1234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
